// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: writeback bypass into operands, load-use stall with
// a single EX bubble, branch flush, and a saturating bubble counter.
module id_ex_stage #(
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              id_valid,
    input  logic [31:0]       id_pc,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic [31:0]       id_rdata1,
    input  logic [31:0]       id_rdata2,
    input  logic [31:0]       id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_reg_write,
    input  logic              wb_reg_write,
    input  logic [4:0]        wb_rd,
    input  logic [31:0]       wb_data,
    input  logic              flush,
    output logic              stall_id,
    output logic              ex_valid,
    output logic [31:0]       ex_pc,
    output logic [31:0]       ex_op1,
    output logic [31:0]       ex_op2,
    output logic [31:0]       ex_imm,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic [4:0]        ex_rd,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_reg_write,
    output logic [CNT_W-1:0]  bubble_count
);

    logic              r_valid, r_mem_read, r_mem_write, r_reg_write;
    logic [31:0]       r_pc, r_op1, r_op2, r_imm;
    logic [4:0]        r_rs1, r_rs2, r_rd;
    logic [CTRL_W-1:0] r_ctrl;
    logic [CNT_W-1:0]  r_bubble_count;

    logic              w_hazard;
    logic [31:0]       w_op1, w_op2;

    // x0 reads as zero even if writeback targets it; same-cycle writes win over regfile data.
    function automatic logic [31:0] sel_op(input logic [4:0] rs, input logic [31:0] rdata,
                                           input logic we, input logic [4:0] wrd,
                                           input logic [31:0] wdata);
        if (rs == 5'd0)
            return 32'd0;
        else if (we && (wrd == rs))
            return wdata;
        else
            return rdata;
    endfunction

    assign w_op1 = sel_op(id_rs1, id_rdata1, wb_reg_write, wb_rd, wb_data);
    assign w_op2 = sel_op(id_rs2, id_rdata2, wb_reg_write, wb_rd, wb_data);

    assign w_hazard = id_valid & r_valid & r_mem_read & (r_rd != 5'd0)
                    & ((r_rd == id_rs1) | (r_rd == id_rs2));
    assign stall_id = w_hazard & ~flush;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_valid        <= 1'b0;
            r_mem_read     <= 1'b0;
            r_mem_write    <= 1'b0;
            r_reg_write    <= 1'b0;
            r_pc           <= '0;
            r_op1          <= '0;
            r_op2          <= '0;
            r_imm          <= '0;
            r_rs1          <= '0;
            r_rs2          <= '0;
            r_rd           <= '0;
            r_ctrl         <= '0;
            r_bubble_count <= '0;
        end else if (flush || w_hazard) begin
            // Data fields hold; only the valid and side-effect flags are killed.
            r_valid     <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_reg_write <= 1'b0;
            if (!flush && (r_bubble_count != {CNT_W{1'b1}}))
                r_bubble_count <= r_bubble_count + CNT_W'(1);
        end else begin
            r_valid     <= id_valid;
            r_mem_read  <= id_mem_read  & id_valid;
            r_mem_write <= id_mem_write & id_valid;
            r_reg_write <= id_reg_write & id_valid;
            r_pc        <= id_pc;
            r_op1       <= w_op1;
            r_op2       <= w_op2;
            r_imm       <= id_imm;
            r_rs1       <= id_rs1;
            r_rs2       <= id_rs2;
            r_rd        <= id_rd;
            r_ctrl      <= id_ctrl;
        end
    end

    assign ex_valid     = r_valid;
    assign ex_pc        = r_pc;
    assign ex_op1       = r_op1;
    assign ex_op2       = r_op2;
    assign ex_imm       = r_imm;
    assign ex_rs1       = r_rs1;
    assign ex_rs2       = r_rs2;
    assign ex_rd        = r_rd;
    assign ex_ctrl      = r_ctrl;
    assign ex_mem_read  = r_mem_read;
    assign ex_mem_write = r_mem_write;
    assign ex_reg_write = r_reg_write;
    assign bubble_count = r_bubble_count;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: capture, bypass, load-use stall, flush,
// counter saturation (narrow counter) and asynchronous reset mid-stall.
module tb_id_ex_stage;
    localparam int CTRL_W = 8;
    localparam int CNT_W  = 4;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              id_valid, id_mem_read, id_mem_write, id_reg_write;
    logic [31:0]       id_pc, id_rdata1, id_rdata2, id_imm;
    logic [4:0]        id_rs1, id_rs2, id_rd;
    logic [CTRL_W-1:0] id_ctrl;
    logic              wb_reg_write, flush;
    logic [4:0]        wb_rd;
    logic [31:0]       wb_data;
    logic              stall_id, ex_valid, ex_mem_read, ex_mem_write, ex_reg_write;
    logic [31:0]       ex_pc, ex_op1, ex_op2, ex_imm;
    logic [4:0]        ex_rs1, ex_rs2, ex_rd;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [CNT_W-1:0]  bubble_count;

    int n_chk  = 0;
    int n_fail = 0;

    id_ex_stage #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset_n(reset_n),
        .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm), .id_ctrl(id_ctrl),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_reg_write(id_reg_write),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
        .stall_id(stall_id), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_op1(ex_op1),
        .ex_op2(ex_op2), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_ctrl(ex_ctrl), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_reg_write(ex_reg_write), .bubble_count(bubble_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then settle outputs before sampling.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [4:0] rd,
                          input logic [31:0] d1, input logic [31:0] d2,
                          input logic mr, input logic mw, input logic rw);
        id_valid = v; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_rdata1 = d1; id_rdata2 = d2;
        id_mem_read = mr; id_mem_write = mw; id_reg_write = rw;
        #1;
    endtask

    initial begin
        reset_n = 1'b0; flush = 1'b0;
        wb_reg_write = 1'b0; wb_rd = '0; wb_data = '0;
        id_imm = 32'hFFFF_FFF0; id_ctrl = 8'h5A;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #12;
        chk("rst_ex_valid", 32'(ex_valid), 0);
        chk("rst_bubbles",  32'(bubble_count), 0);
        chk("rst_stall",    32'(stall_id), 0);
        chk("rst_ex_pc",    ex_pc, 0);
        @(negedge clock); reset_n = 1'b1;

        // 1: plain ADD capture
        step();
        set_id(1, 32'h100, 3, 4, 6, 32'h11, 32'h22, 0, 0, 1);
        chk("t1_stall_pre", 32'(stall_id), 0);
        step();
        chk("t1_ex_valid", 32'(ex_valid), 1);
        chk("t1_op1", ex_op1, 32'h11);
        chk("t1_op2", ex_op2, 32'h22);
        chk("t1_pc",  ex_pc, 32'h100);
        chk("t1_rd",  32'(ex_rd), 6);
        chk("t1_imm", ex_imm, 32'hFFFF_FFF0);
        chk("t1_ctrl", 32'(ex_ctrl), 32'h5A);
        chk("t1_rw",  32'(ex_reg_write), 1);
        chk("t1_mr",  32'(ex_mem_read), 0);

        // 2: load rd=5 then a consumer of x5 in rs2
        set_id(1, 32'h104, 1, 0, 5, 32'h1000, 32'h0, 1, 0, 1);
        chk("t2_stall_load", 32'(stall_id), 0);
        step();
        chk("t2_ld_mr", 32'(ex_mem_read), 1);
        set_id(1, 32'h108, 2, 5, 7, 32'h3, 32'h9, 0, 0, 1);
        chk("t2_stall", 32'(stall_id), 1);
        step();
        chk("t2_bubble_valid", 32'(ex_valid), 0);
        chk("t2_bubble_mr",    32'(ex_mem_read), 0);
        chk("t2_bubble_rw",    32'(ex_reg_write), 0);
        chk("t2_count",        32'(bubble_count), 1);
        chk("t2_stall_clear",  32'(stall_id), 0);
        step();
        chk("t2_adv_valid", 32'(ex_valid), 1);
        chk("t2_adv_pc",    ex_pc, 32'h108);
        chk("t2_adv_op2",   ex_op2, 32'h9);

        // 3: writeback bypass
        set_id(1, 32'h10C, 7, 8, 9, 32'hAAAA, 32'h55, 0, 1, 0);
        wb_reg_write = 1; wb_rd = 7; wb_data = 32'h1234;
        step();
        chk("t3_fwd_op1",  ex_op1, 32'h1234);
        chk("t3_nofwd_op2", ex_op2, 32'h55);
        chk("t3_mw",       32'(ex_mem_write), 1);
        wb_rd = 0;
        step();
        chk("t3_wbx0_op1", ex_op1, 32'hAAAA);
        wb_rd = 7; wb_reg_write = 0;
        step();
        chk("t3_wbdis_op1", ex_op1, 32'hAAAA);
        set_id(1, 32'h110, 9, 7, 10, 32'h1, 32'hBBBB, 0, 0, 1);
        wb_reg_write = 1; wb_data = 32'h4321;
        step();
        chk("t3_fwd_op2", ex_op2, 32'h4321);
        chk("t3_op1",     ex_op1, 32'h1);

        // 4: x0 handling
        set_id(1, 32'h114, 0, 0, 0, 32'h77, 32'h88, 1, 0, 0);
        wb_reg_write = 1; wb_rd = 0; wb_data = 32'hFFFF;
        step();
        chk("t4_x0_op1", ex_op1, 0);
        chk("t4_x0_op2", ex_op2, 0);
        wb_reg_write = 0;
        set_id(1, 32'h118, 0, 0, 3, 32'h0, 32'h0, 0, 0, 1);
        chk("t4_rd0_nostall", 32'(stall_id), 0);
        // id_valid=0 neither stalls nor leaks side-effect flags
        set_id(1, 32'h11C, 1, 1, 5, 32'h0, 32'h0, 1, 0, 1);
        step();
        set_id(0, 32'h120, 5, 5, 6, 32'h0, 32'h0, 1, 1, 1);
        chk("t4_inv_nostall", 32'(stall_id), 0);
        step();
        chk("t4_inv_valid", 32'(ex_valid), 0);
        chk("t4_inv_mr",    32'(ex_mem_read), 0);
        chk("t4_inv_mw",    32'(ex_mem_write), 0);
        chk("t4_count",     32'(bubble_count), 1);

        // 5: flush beats load-use
        set_id(1, 32'h124, 1, 1, 5, 32'h0, 32'h0, 1, 0, 1);
        step();
        set_id(1, 32'h128, 5, 2, 6, 32'h0, 32'h0, 0, 0, 1);
        flush = 1; #1;
        chk("t5_stall", 32'(stall_id), 0);
        step();
        flush = 0;
        chk("t5_valid", 32'(ex_valid), 0);
        chk("t5_mr",    32'(ex_mem_read), 0);
        chk("t5_count", 32'(bubble_count), 1);

        // 6: 2^CNT_W+3 hazards, alternating load and consumer
        for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
            set_id(1, 32'h200, 1, 1, 5, 32'h0, 32'h0, 1, 0, 1);
            step();
            set_id(1, 32'h204, 5, 2, 6, 32'h0, 32'h0, 0, 0, 1);
            step();
        end
        chk("t6_sat", 32'(bubble_count), 32'((1 << CNT_W) - 1));
        set_id(1, 32'h300, 1, 1, 5, 32'h0, 32'h0, 1, 0, 1);
        step();
        set_id(1, 32'h304, 5, 2, 6, 32'h0, 32'h0, 0, 0, 1);
        chk("t6_stall_pre", 32'(stall_id), 1);
        #2 reset_n = 1'b0; #1;
        chk("t6_rst_stall", 32'(stall_id), 0);
        chk("t6_rst_valid", 32'(ex_valid), 0);
        chk("t6_rst_mr",    32'(ex_mem_read), 0);
        chk("t6_rst_pc",    ex_pc, 0);
        chk("t6_rst_rd",    32'(ex_rd), 0);
        chk("t6_rst_count", 32'(bubble_count), 0);
        @(negedge clock); reset_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
